route_lookup_ctrl: RTL and testbench
====================================

Name: route_lookup_ctrl

Overview:
Lookup sequencer between the IPv4 header parser and the TCAM route table. It accepts one destination address per request and issues it to the TCAM as a single-cycle strobe. It then waits a bounded window for a match. It delivers a resolved route (next hop, interface, prefix length, hit flag) to the forwarding stage over a valid/ready handshake. On a miss it substitutes the configured default route.

Parameters:
- TIMEOUT_CYCLES, 8, max cycles after strobe to wait for tcam_valid before declaring a miss (legal range 1..255).
- TAG_W, 8, width of the opaque packet tag carried from request to result.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_dst_ip  in  32  destination IPv4 address.
- req_tag  in  TAG_W  packet tag.
- tcam_addr  out  32  address presented to the TCAM, held stable from strobe until the result is captured.
- tcam_strobe  out  1  one-cycle lookup pulse (drives the TCAM clk/enable input).
- tcam_valid  in  1  TCAM match indication.
- tcam_next_hop  in  32  matched next hop.
- tcam_if_idx  in  4  matched interface index.
- tcam_prefix_size  in  8  matched prefix length.
- cfg_def_next_hop  in  32  default-route next hop.
- cfg_def_if_idx  in  4  default-route interface.
- res_valid  out  1  result present.
- res_ready  in  1  downstream accepts the result.
- res_next_hop  out  32  resolved next hop.
- res_if_idx  out  4  resolved interface.
- res_prefix_size  out  8  resolved prefix length; 0 on miss.
- res_hit  out  1  1 means the TCAM matched; 0 means the default route was used.
- res_tag  out  TAG_W  tag echoed from the request.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE.
  - req_ready=1; tcam_strobe=0; tcam_addr=0.
  - res_valid=0; all res_* fields=0; busy=0; wait counter=0.
  - Reset mid-lookup or mid-hold drops the pending result with no output.
- States:
  - IDLE: req_ready=1. When req_valid is high, latch req_dst_ip into tcam_addr and req_tag into the tag register, then go to ISSUE. req_ready drops the cycle after acceptance.
  - ISSUE: tcam_strobe=1 for exactly this one cycle. Clear the counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - If tcam_valid=1 and tcam_prefix_size<=32: capture the TCAM fields, set res_hit=1, go to HOLD.
    - If tcam_valid=1 and tcam_prefix_size>32: treat as malformed; load the default route, set res_hit=0, res_prefix_size=0, go to HOLD.
    - Else, if counter==TIMEOUT_CYCLES-1: load the default route, set res_hit=0, res_prefix_size=0, go to HOLD.
    - tcam_valid in the same cycle as the timeout wins (counts as a hit).
  - HOLD: res_valid=1 and all res_* fields stable until res_ready=1.
    - On handshake, return to IDLE; res_valid falls the next cycle.
    - A request is not accepted in the handshake cycle, so the minimum spacing between requests is 4 cycles.
- Latency: request accepted at cycle 0, strobe at cycle 1, earliest res_valid at cycle 3 (tcam_valid at cycle 2). Worst-case res_valid is at cycle 2+TIMEOUT_CYCLES.
- tcam_valid outside WAIT (stale or late responses) is ignored.
- Counter width is 8 bits; it never wraps because the exit at TIMEOUT_CYCLES-1 is forced.

Optional Feature:
- Macro: ROUTE_STATS_EN.
- When defined, adds these ports:
  - stat_clr  in  1
  - stat_hits  out  32
  - stat_misses  out  32
- stat_hits increments on entry to HOLD with res_hit=1; stat_misses increments on entry to HOLD with res_hit=0.
- Both counters saturate at 0xFFFFFFFF and are cleared by rst or stat_clr.
- stat_clr takes priority over a same-cycle increment.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Hit path: req_dst_ip=0xC0A80001, tag=0x11. Return tcam_valid one cycle after the strobe with next_hop=0x0A000001, if_idx=3, prefix=24 → res_valid at cycle 3 with those values, res_hit=1, res_tag=0x11, res_prefix_size=24.
- Miss/timeout: no tcam_valid; cfg default next hop 0x0A0000FE, if_idx=0 → res_valid at cycle 2+8=10 with 0x0A0000FE, if 0, prefix 0, hit 0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → outputs stable, req_ready=0, no new strobe. Release → one transfer, then IDLE.
- Edge cases:
  - tcam_valid on the last wait cycle → hit.
  - tcam_valid with prefix 40 → default route, hit=0.
  - tcam_valid pulse in IDLE → ignored.
- Reset during WAIT: assert rst for 1 cycle → no res_valid, req_ready=1 next cycle, and the following request completes normally.
- With ROUTE_STATS_EN: run 3 hits and 2 misses → stat_hits=3, stat_misses=2. Assert stat_clr concurrent with a hit → both counters 0.

Source files
------------

// File: rtl/route_lookup_ctrl.sv
// route_lookup_ctrl: issues one destination address per request to the TCAM
// route table, waits a bounded window for a match and hands the resolved
// route (or the configured default route) downstream over valid/ready.
// Optional build macro ROUTE_STATS_EN adds saturating hit/miss counters
// with a synchronous clear (stat_clr, stat_hits, stat_misses).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request; latches address and tag on req_valid
// S_ISSUE | one-cycle TCAM strobe; wait counter cleared
// S_WAIT  | counting cycles until a TCAM response or the timeout
// S_HOLD  | result presented on res_*; leaves on res_ready
module route_lookup_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned TAG_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_dst_ip,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      tcam_addr,
  output logic             tcam_strobe,
  input  logic             tcam_valid,
  input  logic [31:0]      tcam_next_hop,
  input  logic [3:0]       tcam_if_idx,
  input  logic [7:0]       tcam_prefix_size,
  input  logic [31:0]      cfg_def_next_hop,
  input  logic [3:0]       cfg_def_if_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_next_hop,
  output logic [3:0]       res_if_idx,
  output logic [7:0]       res_prefix_size,
  output logic             res_hit,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
`ifdef ROUTE_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // The counter exits WAIT at this value, so it tops out at LAST_CNT+1 <= 255.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      nh_q, nh_d;
  logic [3:0]       if_q, if_d;
  logic [7:0]       pfx_q, pfx_d;
  logic             hit_q, hit_d;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      nh_q    <= '0;
      if_q    <= '0;
      pfx_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      nh_q    <= nh_d;
      if_q    <= if_d;
      pfx_q   <= pfx_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state logic; a response in the timeout cycle still counts as a hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (tcam_valid || (cnt_q == LAST_CNT)) state_d = S_HOLD;
      S_HOLD:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request capture, wait counter, result selection.
  always_comb begin
    addr_d = addr_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    nh_d   = nh_q;
    if_d   = if_q;
    pfx_d  = pfx_q;
    hit_d  = hit_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_dst_ip;
          tag_d  = req_tag;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (tcam_valid && (tcam_prefix_size <= 8'd32)) begin
          nh_d  = tcam_next_hop;
          if_d  = tcam_if_idx;
          pfx_d = tcam_prefix_size;
          hit_d = 1'b1;
        end else if (tcam_valid || (cnt_q == LAST_CNT)) begin
          // A prefix longer than 32 bits is malformed and treated as a miss.
          nh_d  = cfg_def_next_hop;
          if_d  = cfg_def_if_idx;
          pfx_d = 8'd0;
          hit_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state plus registered result fields.
  always_comb begin
    req_ready       = (state_q == S_IDLE);
    tcam_strobe     = (state_q == S_ISSUE);
    res_valid       = (state_q == S_HOLD);
    busy            = (state_q != S_IDLE);
    tcam_addr       = addr_q;
    res_next_hop    = nh_q;
    res_if_idx      = if_q;
    res_prefix_size = pfx_q;
    res_hit         = hit_q;
    res_tag         = tag_q;
  end

`ifdef ROUTE_STATS_EN
  logic        hold_entry;
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // Saturating counters bumped on entry to HOLD; clear beats increment.
  always_comb begin
    hold_entry = (state_q == S_WAIT) && (state_d == S_HOLD);
    hits_d     = hits_q;
    misses_d   = misses_q;
    if (stat_clr) begin
      hits_d   = '0;
      misses_d = '0;
    end else if (hold_entry) begin
      if (hit_d && (hits_q != 32'hFFFF_FFFF))
        hits_d = hits_q + 32'd1;
      if (!hit_d && (misses_q != 32'hFFFF_FFFF))
        misses_d = misses_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_route_lookup_ctrl.sv
// Testbench for route_lookup_ctrl: directed cases with literal expectations
// followed by randomized transactions checked every cycle against a
// transaction-timing model (accept cycle, result window, expected fields).
module tb_route_lookup_ctrl;
  localparam int T  = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_dst_ip;
  logic [TW-1:0] req_tag;
  logic [31:0]   tcam_addr;
  logic          tcam_strobe;
  logic          tcam_valid;
  logic [31:0]   tcam_next_hop;
  logic [3:0]    tcam_if_idx;
  logic [7:0]    tcam_prefix_size;
  logic [31:0]   cfg_def_next_hop;
  logic [3:0]    cfg_def_if_idx;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_next_hop;
  logic [3:0]    res_if_idx;
  logic [7:0]    res_prefix_size;
  logic          res_hit;
  logic [TW-1:0] res_tag;
  logic          busy;
`ifdef ROUTE_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
`endif

  route_lookup_ctrl #(.TIMEOUT_CYCLES(T), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_ip(req_dst_ip), .req_tag(req_tag),
    .tcam_addr(tcam_addr), .tcam_strobe(tcam_strobe),
    .tcam_valid(tcam_valid), .tcam_next_hop(tcam_next_hop),
    .tcam_if_idx(tcam_if_idx), .tcam_prefix_size(tcam_prefix_size),
    .cfg_def_next_hop(cfg_def_next_hop), .cfg_def_if_idx(cfg_def_if_idx),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_next_hop(res_next_hop), .res_if_idx(res_if_idx),
    .res_prefix_size(res_prefix_size), .res_hit(res_hit),
    .res_tag(res_tag), .busy(busy)
`ifdef ROUTE_STATS_EN
    , .stat_clr(stat_clr), .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model of the transaction in flight: accept cycle, result window, fields.
  logic          chk_en = 1'b0;
  int            e_a = -100, e_start = -100, e_end = -100;
  logic [31:0]   e_ip = '0, e_nh = '0;
  logic [3:0]    e_if = '0;
  logic [7:0]    e_pfx = '0;
  logic [TW-1:0] e_tag = '0;
  logic          e_hit = 1'b0;

  // Observations of the first result cycle, for literal checks.
  int            obs_lat = -1, obs_len = 0;
  logic [31:0]   obs_nh = '0;
  logic [3:0]    obs_if = '0;
  logic [7:0]    obs_pfx = '0;
  logic          obs_hit = 1'b0;
  logic [TW-1:0] obs_tag = '0;
  logic          prev_rv = 1'b0;
`ifdef ROUTE_STATS_EN
  logic [31:0]   m_hits = '0, m_misses = '0;
  logic          clr_prev = 1'b0, rst_prev = 1'b0;
`endif

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit busy_e, rv_e;
    if (chk_en) begin
      busy_e = (cyc >= e_a + 1) && (cyc <= e_end);
      rv_e   = (cyc >= e_start) && (cyc <= e_end);
      chk("busy", 32'(busy), 32'(busy_e));
      chk("req_ready", 32'(req_ready), 32'(!busy_e));
      chk("tcam_strobe", 32'(tcam_strobe), 32'(cyc == e_a + 1));
      chk("res_valid", 32'(res_valid), 32'(rv_e));
      if (busy_e) chk("tcam_addr", tcam_addr, e_ip);
      if (rv_e) begin
        chk("res_next_hop", res_next_hop, e_nh);
        chk("res_if_idx", 32'(res_if_idx), 32'(e_if));
        chk("res_prefix_size", 32'(res_prefix_size), 32'(e_pfx));
        chk("res_hit", 32'(res_hit), 32'(e_hit));
        chk("res_tag", 32'(res_tag), 32'(e_tag));
      end
      if (res_valid && !prev_rv) begin
        obs_lat = cyc - e_a;
        obs_len = 0;
        obs_nh  = res_next_hop;
        obs_if  = res_if_idx;
        obs_pfx = res_prefix_size;
        obs_hit = res_hit;
        obs_tag = res_tag;
      end
      if (res_valid) obs_len++;
      prev_rv = res_valid;
`ifdef ROUTE_STATS_EN
      if (clr_prev || rst_prev) begin
        m_hits   = '0;
        m_misses = '0;
      end else if (cyc == e_start) begin
        if (e_hit) begin
          if (m_hits != 32'hFFFF_FFFF) m_hits++;
        end else begin
          if (m_misses != 32'hFFFF_FFFF) m_misses++;
        end
      end
      chk("stat_hits", stat_hits, m_hits);
      chk("stat_misses", stat_misses, m_misses);
      clr_prev = stat_clr;
      rst_prev = rst;
`endif
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tcam_valid       = ($urandom % 3 == 0);
      tcam_next_hop    = $urandom;
      tcam_if_idx      = 4'($urandom);
      tcam_prefix_size = 8'($urandom);
      nc();
    end
    tcam_valid = 1'b0;
  endtask

  // One lookup: TCAM answers k cycles after the strobe (k > T means too late),
  // downstream stalls h cycles. Optionally pre-asserts the next request in
  // the handshake cycle, where it must not be accepted.
  task automatic txn(input logic [31:0] ip, input logic [TW-1:0] tag, input int k,
                     input logic [31:0] nh, input logic [3:0] ifx, input logic [7:0] pfx,
                     input int h, input logic [31:0] dnh, input logic [3:0] dif,
                     input bit stray, input bit clr, input bit nxt_early,
                     input logic [31:0] nxt_ip, input logic [TW-1:0] nxt_tag);
    int a, st, en;
    bit hit;
    a   = cyc;
    hit = (k <= T) && (pfx <= 8'd32);
    st  = (k <= T) ? a + 2 + k : a + 2 + T;
    en  = st + h;
    e_ip = ip; e_tag = tag; e_hit = hit;
    e_nh  = hit ? nh : dnh;
    e_if  = hit ? ifx : dif;
    e_pfx = hit ? pfx : 8'd0;
    e_a = a; e_start = st; e_end = en;
    obs_lat = -1;
    req_valid = 1'b1; req_dst_ip = ip; req_tag = tag;
    cfg_def_next_hop = dnh; cfg_def_if_idx = dif;
    tcam_valid = 1'b0;
    for (int t = a + 1; t <= en; t++) begin
      nc();
      if (t == a + 1) begin
        req_valid = 1'b0; req_dst_ip = $urandom; req_tag = TW'($urandom);
      end
      if (t == a + 1 + k) begin
        tcam_valid = 1'b1; tcam_next_hop = nh; tcam_if_idx = ifx; tcam_prefix_size = pfx;
      end else if (stray && (t == a + 1 || t >= st) && ($urandom % 3 == 0)) begin
        tcam_valid = 1'b1; tcam_next_hop = $urandom;
        tcam_if_idx = 4'($urandom); tcam_prefix_size = 8'($urandom);
      end else begin
        tcam_valid = 1'b0;
      end
`ifdef ROUTE_STATS_EN
      stat_clr = clr && (t == st - 1);
`endif
      res_ready = (t == en);
      if (t == en && nxt_early) begin
        req_valid = 1'b1; req_dst_ip = nxt_ip; req_tag = nxt_tag;
      end
    end
    nc();
    res_ready  = 1'b0;
    tcam_valid = 1'b0;
`ifdef ROUTE_STATS_EN
    stat_clr = 1'b0;
`else
    if (clr) ;
`endif
  endtask

  // Request accepted, then reset pulsed for one cycle while in WAIT.
  task automatic rst_mid(input logic [31:0] ip, input logic [TW-1:0] tag);
    int a;
    a = cyc;
    e_a = a; e_start = 1 << 30; e_end = a + 3; e_ip = ip;
    req_valid = 1'b1; req_dst_ip = ip; req_tag = tag;
    nc();
    req_valid = 1'b0;
    nc();
    nc();
    rst = 1'b1;
    nc();
    rst = 1'b0;
  endtask

  logic [31:0]   n_ip;
  logic [TW-1:0] n_tag;
  bit            n_early;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_dst_ip = '0; req_tag = '0;
    tcam_valid = 1'b0; tcam_next_hop = '0; tcam_if_idx = '0; tcam_prefix_size = '0;
    cfg_def_next_hop = 32'h0A00_00FE; cfg_def_if_idx = 4'd0; res_ready = 1'b0;
`ifdef ROUTE_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) nc();
    rst = 1'b0;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst tcam_strobe", 32'(tcam_strobe), 32'd0);
    chk("rst tcam_addr", tcam_addr, 32'd0);
    chk("rst res_next_hop", res_next_hop, 32'd0);
    chk("rst res_tag", 32'(res_tag), 32'd0);
    chk("rst res_hit", 32'(res_hit), 32'd0);
    chk_en = 1'b1;

    idle(4);

    txn(32'hC0A8_0001, 8'h11, 1, 32'h0A00_0001, 4'd3, 8'd24, 0,
        32'h0A00_00FE, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("hit latency", 32'(obs_lat), 32'd3);
    chk("hit next_hop", obs_nh, 32'h0A00_0001);
    chk("hit if_idx", 32'(obs_if), 32'd3);
    chk("hit prefix", 32'(obs_pfx), 32'd24);
    chk("hit flag", 32'(obs_hit), 32'd1);
    chk("hit tag", 32'(obs_tag), 32'h11);

    txn(32'h0A0A_0A0A, 8'h22, T + 1, 32'h1234_5678, 4'd5, 8'd16, 5,
        32'h0A00_00FE, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("timeout latency", 32'(obs_lat), 32'd10);
    chk("timeout next_hop", obs_nh, 32'h0A00_00FE);
    chk("timeout prefix", 32'(obs_pfx), 32'd0);
    chk("timeout hit", 32'(obs_hit), 32'd0);
    chk("backpressure hold len", 32'(obs_len), 32'd6);

    txn(32'h0102_0304, 8'h33, T, 32'h0B00_0001, 4'd7, 8'd32, 1,
        32'h0A00_00FE, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("last-cycle latency", 32'(obs_lat), 32'd10);
    chk("last-cycle hit", 32'(obs_hit), 32'd1);
    chk("last-cycle prefix", 32'(obs_pfx), 32'd32);

    txn(32'h0506_0708, 8'h44, 2, 32'h0C00_0001, 4'd9, 8'd40, 0,
        32'h0A00_00FE, 4'd2, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("malformed latency", 32'(obs_lat), 32'd4);
    chk("malformed hit", 32'(obs_hit), 32'd0);
    chk("malformed prefix", 32'(obs_pfx), 32'd0);
    chk("malformed next_hop", obs_nh, 32'h0A00_00FE);
    chk("malformed if_idx", 32'(obs_if), 32'd2);

    rst_mid(32'h0909_0909, 8'h55);
    chk("post-rst res_next_hop", res_next_hop, 32'd0);
    chk("post-rst res_tag", 32'(res_tag), 32'd0);
    chk("post-rst res_prefix", 32'(res_prefix_size), 32'd0);
    chk("post-rst tcam_addr", tcam_addr, 32'd0);

`ifdef ROUTE_STATS_EN
    for (int i = 0; i < 5; i++)
      txn($urandom, 8'(i), (i < 3) ? 2 : T + 1, $urandom, 4'd1, 8'd8, 0,
          32'h0A00_00FE, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("stats 3 hits", stat_hits, 32'd3);
    chk("stats 2 misses", stat_misses, 32'd2);
    txn(32'h0707_0707, 8'h77, 3, 32'h0D00_0001, 4'd4, 8'd20, 1,
        32'h0A00_00FE, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0);
    chk("stats clr hits", stat_hits, 32'd0);
    chk("stats clr misses", stat_misses, 32'd0);
`endif

    txn(32'hC0A8_0002, 8'h66, 1, 32'h0A00_0002, 4'd6, 8'd28, 0,
        32'h0A00_00FE, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("after-rst latency", 32'(obs_lat), 32'd3);
    chk("after-rst tag", 32'(obs_tag), 32'h66);

    n_ip = $urandom; n_tag = TW'($urandom); n_early = 1'b0;
    for (int i = 0; i < 150; i++) begin
      logic [31:0]   c_ip;
      logic [TW-1:0] c_tag;
      logic [7:0]    pfx;
      int            k, h;
      c_ip  = n_ip;
      c_tag = n_tag;
      n_ip  = $urandom;
      n_tag = TW'($urandom);
      n_early = ($urandom % 3 == 0) && (i < 149);
      k   = $urandom_range(1, T + 1);
      pfx = ($urandom % 4 == 0) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(0, 32));
      h   = ($urandom % 3 == 0) ? $urandom_range(1, 6) : 0;
      txn(c_ip, c_tag, k, $urandom, 4'($urandom), pfx, h, $urandom, 4'($urandom),
          1'b1, 1'b0, n_early, n_ip, n_tag);
      if (!n_early) idle($urandom_range(0, 3));
    end

    idle(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
